// File: rtl/alu_if_pkg.sv
// Shared widths, control-path encodings and issuer state type for the ALU operand interface.
package alu_if_pkg;
    localparam int NUM_W   = 5;
    localparam int PRINT_W = 6;
    localparam int RES_W   = 32;

    localparam logic CTRL_MA = 1'b0;
    localparam logic CTRL_MB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } issuer_state_t;
endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command to the ALU, waits its registered latency, and returns the captured result.
// state | meaning
// IDLE  | ready for a command; alu_* hold the last accepted operands
// WAIT  | operands on the ALU; wait_cnt counts down to the capture edge
// RESP  | rsp_* held until the consumer takes the response
module alu_cmd_issuer
    import alu_if_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ctrl,
    input  logic [NUM_W-1:0]   cmd_num1,
    input  logic [NUM_W-1:0]   cmd_num2,
    input  logic [PRINT_W-1:0] cmd_print,
    output logic               alu_controlBit,
    output logic [NUM_W-1:0]   alu_Number1,
    output logic [NUM_W-1:0]   alu_Number2,
    output logic [PRINT_W-1:0] alu_printout,
    input  logic [RES_W-1:0]   alu_conclusion,
    input  logic               alu_balancebit,
    input  logic               alu_equalityBit,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [RES_W-1:0]   rsp_conclusion,
    output logic               rsp_balance,
    output logic               rsp_equal,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count,
    output logic [CNT_W-1:0]   eq_count
);
    localparam int WCW = $clog2(LATENCY + 1);

    issuer_state_t  state, state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           accept, capture, rsp_fire;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                accept    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (wait_cnt == '0) begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_fire  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cmd_ready is held low while reset is asserted so nothing looks acceptable then.
    always_comb begin
        cmd_ready = (state == IDLE) && !reset;
        busy      = (state != IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_controlBit <= 1'b0;
            alu_Number1    <= '0;
            alu_Number2    <= '0;
            alu_printout   <= '0;
            wait_cnt       <= '0;
            rsp_conclusion <= '0;
            rsp_balance    <= 1'b0;
            rsp_equal      <= 1'b0;
        end else begin
            if (accept) begin
                alu_controlBit <= cmd_ctrl;
                alu_Number1    <= cmd_num1;
                alu_Number2    <= cmd_num2;
                alu_printout   <= cmd_print;
                wait_cnt       <= WCW'(LATENCY);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WCW'(1);
            end
            if (capture) begin
                rsp_conclusion <= alu_conclusion;
                rsp_balance    <= alu_balancebit;
                rsp_equal      <= alu_equalityBit;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_op_count (
        .clock (clock),
        .reset (reset),
        .inc   (rsp_fire),
        .count (op_count)
    );

    sat_counter #(.W(CNT_W)) u_eq_count (
        .clock (clock),
        .reset (reset),
        .inc   (rsp_fire && rsp_equal),
        .count (eq_count)
    );
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: default instance plus a LATENCY=3 / CNT_W=2 instance.
module tb_alu_cmd_issuer;
    import alu_if_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    logic        cmd_valid, cmd_ready, cmd_ctrl;
    logic [4:0]  cmd_num1, cmd_num2;
    logic [5:0]  cmd_print;
    logic        alu_controlBit;
    logic [4:0]  alu_Number1, alu_Number2;
    logic [5:0]  alu_printout;
    logic [31:0] alu_conclusion;
    logic        alu_balancebit, alu_equalityBit;
    logic        rsp_valid, rsp_ready, rsp_balance, rsp_equal, busy;
    logic [31:0] rsp_conclusion;
    logic [7:0]  op_count, eq_count;

    logic        p_cmd_valid, p_cmd_ready;
    logic        p_alu_controlBit;
    logic [4:0]  p_alu_Number1, p_alu_Number2;
    logic [5:0]  p_alu_printout;
    logic [31:0] p_alu_conclusion;
    logic        p_alu_equalityBit;
    logic        p_rsp_valid, p_rsp_ready, p_rsp_balance, p_rsp_equal, p_busy;
    logic [31:0] p_rsp_conclusion;
    logic [1:0]  p_op_count, p_eq_count;

    alu_cmd_issuer dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl),
        .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_print(cmd_print),
        .alu_controlBit(alu_controlBit), .alu_Number1(alu_Number1),
        .alu_Number2(alu_Number2), .alu_printout(alu_printout),
        .alu_conclusion(alu_conclusion), .alu_balancebit(alu_balancebit),
        .alu_equalityBit(alu_equalityBit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_conclusion(rsp_conclusion), .rsp_balance(rsp_balance),
        .rsp_equal(rsp_equal), .busy(busy),
        .op_count(op_count), .eq_count(eq_count)
    );

    alu_cmd_issuer #(.LATENCY(3), .CNT_W(2)) dut_p (
        .clock(clock), .reset(reset),
        .cmd_valid(p_cmd_valid), .cmd_ready(p_cmd_ready), .cmd_ctrl(CTRL_MB),
        .cmd_num1(5'd3), .cmd_num2(5'd3), .cmd_print(6'd1),
        .alu_controlBit(p_alu_controlBit), .alu_Number1(p_alu_Number1),
        .alu_Number2(p_alu_Number2), .alu_printout(p_alu_printout),
        .alu_conclusion(p_alu_conclusion), .alu_balancebit(1'b0),
        .alu_equalityBit(p_alu_equalityBit),
        .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready),
        .rsp_conclusion(p_rsp_conclusion), .rsp_balance(p_rsp_balance),
        .rsp_equal(p_rsp_equal), .busy(p_busy),
        .op_count(p_op_count), .eq_count(p_eq_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        ctrl;
        logic [4:0]  n1;
        logic [4:0]  n2;
        logic [5:0]  pr;
        logic [31:0] concl;
        logic        bal;
        logic        eq;
        int          exp_op;
        int          exp_eq;
    } vec_t;

    vec_t vecs[4];

    // Full transaction on the default instance: accept, expect capture two edges later, handshake.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        cmd_ctrl        = v.ctrl;
        cmd_num1        = v.n1;
        cmd_num2        = v.n2;
        cmd_print       = v.pr;
        alu_conclusion  = v.concl;
        alu_balancebit  = v.bal;
        alu_equalityBit = v.eq;
        chk({tag, "_ready_before"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ctrl"}, alu_controlBit, v.ctrl);
        chk({tag, "_num1"}, alu_Number1, v.n1);
        chk({tag, "_num2"}, alu_Number2, v.n2);
        chk({tag, "_print"}, alu_printout, v.pr);
        n = 0;
        while (!rsp_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 2);
        chk({tag, "_ctrl_hold"}, alu_controlBit, v.ctrl);
        chk({tag, "_concl"}, rsp_conclusion, v.concl);
        chk({tag, "_bal"}, rsp_balance, v.bal);
        chk({tag, "_eq"}, rsp_equal, v.eq);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, rsp_valid, 0);
        chk({tag, "_ready_after"}, cmd_ready, 1);
        chk({tag, "_op_count"}, op_count, v.exp_op);
        chk({tag, "_eq_count"}, eq_count, v.exp_eq);
    endtask

    initial begin
        vec_t v;
        logic seen;

        vecs[0] = '{CTRL_MA, 5'd9, 5'd9, 6'd2, 32'h0000_0012, 1'b0, 1'b1, 3, 2};
        vecs[1] = '{CTRL_MA, 5'd9, 5'd9, 6'd2, 32'h0000_0012, 1'b0, 1'b1, 4, 3};
        vecs[2] = '{CTRL_MA, 5'd9, 5'd9, 6'd2, 32'h0000_0012, 1'b0, 1'b1, 5, 4};
        vecs[3] = '{CTRL_MB, 5'd9, 5'd4, 6'd5, 32'h0000_0005, 1'b1, 1'b0, 6, 4};

        reset = 1'b1;
        cmd_valid = 1'b1; cmd_ctrl = 1'b1; cmd_num1 = 5'd31; cmd_num2 = 5'd31; cmd_print = 6'd63;
        alu_conclusion = 32'hDEAD_BEEF; alu_balancebit = 1'b1; alu_equalityBit = 1'b1;
        rsp_ready = 1'b1;
        p_cmd_valid = 1'b1; p_rsp_ready = 1'b0; p_alu_conclusion = '0; p_alu_equalityBit = 1'b1;

        // Reset held two edges with a command pending
        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu", {alu_controlBit, alu_Number1, alu_Number2, alu_printout}, 0);
        chk("rst_rsp", {rsp_conclusion[30:0], rsp_balance}, 0);
        chk("rst_counts", {op_count, eq_count, p_op_count, p_eq_count}, 0);
        reset = 1'b0; cmd_valid = 1'b0; p_cmd_valid = 1'b0; rsp_ready = 1'b0;
        step();
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Single operation
        v = '{CTRL_MA, 5'd12, 5'd7, 6'd3, 32'h0000_0013, 1'b1, 1'b0, 1, 0};
        run_op(v, "single");

        // Backpressure: response must freeze, commands ignored
        cmd_ctrl = CTRL_MB; cmd_num1 = 5'd5; cmd_num2 = 5'd6; cmd_print = 6'd7;
        alu_conclusion = 32'h0000_ABCD; alu_balancebit = 1'b0; alu_equalityBit = 1'b1;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("bp_rsp_valid", rsp_valid, 1);
        alu_conclusion = 32'hFFFF_FFFF; alu_equalityBit = 1'b0;
        cmd_num1 = 5'd31; cmd_num2 = 5'd30; cmd_print = 6'd40; cmd_ctrl = CTRL_MA;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = i[0];
            step();
            chk("bp_concl", rsp_conclusion, 32'h0000_ABCD);
            chk("bp_eq", rsp_equal, 1);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_alu", {alu_controlBit, alu_Number1, alu_Number2, alu_printout},
                {1'b1, 5'd5, 5'd6, 6'd7});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_op_count", op_count, 2);
        chk("bp_eq_count", eq_count, 1);
        step();
        chk("bp_no_extra_accept", busy, 0);
        chk("bp_alu_kept", alu_Number1, 5);

        // Statistics table
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset one edge after acceptance
        cmd_ctrl = CTRL_MB; cmd_num1 = 5'd17; cmd_num2 = 5'd2; cmd_print = 6'd9;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_busy_clr", busy, 0);
        chk("mid_counts", {op_count, eq_count}, 0);
        chk("mid_alu", {alu_controlBit, alu_Number1, alu_Number2, alu_printout}, 0);
        seen = rsp_valid;
        for (int i = 0; i < 4; i++) begin
            step();
            seen = seen | rsp_valid;
        end
        chk("mid_no_rsp", seen, 0);
        chk("mid_ready", cmd_ready, 1);

        // LATENCY=3, CNT_W=2 instance: capture at k+4, counters stick at 3
        for (int i = 0; i < 5; i++) begin
            p_alu_conclusion = 32'd100 + 32'(i);
            p_cmd_valid = 1'b1;
            step();
            p_cmd_valid = 1'b0;
            seen = 1'b0;
            for (int j = 0; j < 3; j++) begin
                step();
                seen = seen | p_rsp_valid;
            end
            chk("p_early_rsp", seen, 0);
            step();
            chk("p_rsp_valid", p_rsp_valid, 1);
            chk("p_concl", p_rsp_conclusion, 32'd100 + 32'(i));
            p_rsp_ready = 1'b1;
            step();
            p_rsp_ready = 1'b0;
            chk("p_op_count", p_op_count, (i + 1 > 3) ? 3 : i + 1);
            chk("p_eq_count", p_eq_count, (i + 1 > 3) ? 3 : i + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
